// File: rtl/rdd_pkg.sv
// Shared definitions for the restoring-divider arbiter: FSM state encoding,
// response status codes and a small modular-add helper used by the
// round-robin search and the pointer update.
package rdd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arbState_e;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  // Adds two values that are each already below the modulus and wraps the
  // sum back into range; cheaper than a true modulo for our small N_REQ.
  function automatic int wrapAdd(input int base, input int offset, input int modulus);
    int sum;
    sum = base + offset;
    if (sum >= modulus) begin
      sum = sum - modulus;
    end
    return sum;
  endfunction

endpackage

// File: rtl/rdd_arbiter_rr_grant.sv
// Combinational round-robin priority search. Starting at i_ptr and walking
// upward with wrap-around, the first asserted request wins. Produces the
// winner both as a one-hot vector and as a binary index.
module rr_grant #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_oneHot,
  output logic [IW-1:0]    o_index,
  output logic             o_any
);

  import rdd_pkg::*;

  // Walk the candidates in priority order (ptr, ptr+1, ...) and keep the
  // first valid one; later hits are masked by o_any once a winner exists.
  always_comb begin
    o_oneHot = '0;
    o_index  = '0;
    o_any    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!o_any && i_valid[IW'(wrapAdd(int'(i_ptr), k, N_REQ))]) begin
        o_any    = 1'b1;
        o_index  = IW'(wrapAdd(int'(i_ptr), k, N_REQ));
        o_oneHot[IW'(wrapAdd(int'(i_ptr), k, N_REQ))] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rdd_arbiter.sv
// Round-robin arbiter and sequencer sharing one external restoring divider
// between N_REQ requesters. One request is in flight at a time: it is
// accepted in IDLE, the divider is kicked in ISSUE, WAIT watches for done or
// a timeout, and RESP pulses the tagged result onto the shared response bus.
// Divide-by-zero is answered locally without touching the divider.
module rdd_arbiter #(
  parameter int W       = 8,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64,
  parameter int IW      = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_x,
  input  logic [N_REQ*W-1:0] req_y,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  output logic [IW-1:0]      rsp_id,
  output logic [W-1:0]       rsp_q,
  output logic [W-1:0]       rsp_r,
  output logic [1:0]         rsp_err,
  output logic               busy,
  output logic [W-1:0]       div_x,
  output logic [W-1:0]       div_y,
  output logic               div_start,
  input  logic               div_done,
  input  logic [W-1:0]       div_q,
  input  logic [W-1:0]       div_r
);

  import rdd_pkg::*;

  localparam int CW = $clog2(TIMEOUT);

  arbState_e        r_state;
  arbState_e        w_nextState;

  logic [IW-1:0]    r_rrPtr;
  logic [IW-1:0]    r_id;
  logic [W-1:0]     r_x;
  logic [W-1:0]     r_y;
  logic [CW-1:0]    r_cnt;

  logic [IW-1:0]    r_rspId;
  logic [W-1:0]     r_rspQ;
  logic [W-1:0]     r_rspR;
  logic [1:0]       r_rspErr;

  logic [N_REQ-1:0] w_grantOneHot;
  logic [IW-1:0]    w_grantIdx;
  logic             w_grantAny;
  logic [W-1:0]     w_selX;
  logic [W-1:0]     w_selY;
  logic             w_selYZero;
  logic             w_accept;
  logic             w_timeout;

  rr_grant #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rrGrant (
    .i_valid  (req_valid),
    .i_ptr    (r_rrPtr),
    .o_oneHot (w_grantOneHot),
    .o_index  (w_grantIdx),
    .o_any    (w_grantAny)
  );

  assign w_selX     = req_x[int'(w_grantIdx)*W +: W];
  assign w_selY     = req_y[int'(w_grantIdx)*W +: W];
  assign w_selYZero = (w_selY == '0);
  assign w_accept   = (r_state == ST_IDLE) && w_grantAny && reset;
  assign w_timeout  = (r_cnt == CW'(TIMEOUT - 1));

  assign div_x   = r_x;
  assign div_y   = r_y;
  assign rsp_id  = r_rspId;
  assign rsp_q   = r_rspQ;
  assign rsp_r   = r_rspR;
  assign rsp_err = r_rspErr;

  // State register; reset wins from any state, even mid-division, and the
  // divider is simply abandoned (its late done lands outside WAIT).
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A zero divisor skips the divider entirely, and in WAIT
  // a done arriving on the timeout cycle still counts as a normal finish.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grantAny) begin
          w_nextState = w_selYZero ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_nextState = ST_WAIT;
      end
      ST_WAIT: begin
        if (div_done || w_timeout) begin
          w_nextState = ST_RESP;
        end
      end
      ST_RESP: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Moore-style strobes plus the combinational accept strobe. req_ready is
  // gated by reset so a request shown during a reset cycle is not dropped
  // after the requester believes it was taken.
  always_comb begin
    req_ready = '0;
    div_start = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (reset) begin
          req_ready = w_grantOneHot;
        end
      end
      ST_ISSUE: begin
        div_start = 1'b1;
        busy      = 1'b1;
      end
      ST_WAIT: begin
        busy = 1'b1;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Request capture: operands and id are frozen at accept time so the
  // divider sees stable inputs no matter what the requester does next, and
  // the round-robin pointer moves just past the winner.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_id    <= '0;
      r_rrPtr <= '0;
    end else if (w_accept) begin
      r_x     <= w_selX;
      r_y     <= w_selY;
      r_id    <= w_grantIdx;
      r_rrPtr <= IW'(wrapAdd(int'(w_grantIdx), 1, N_REQ));
    end
  end

  // Watchdog counter: cleared while the start pulse goes out, then counts
  // every WAIT cycle so a divider that never answers can be abandoned.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_cnt <= '0;
    end else if (r_state == ST_WAIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Response bus registers. They are written only when a transaction
  // finishes, so they keep the last result after the rsp_valid pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rspId  <= '0;
      r_rspQ   <= '0;
      r_rspR   <= '0;
      r_rspErr <= ERR_OK;
    end else if (w_accept && w_selYZero) begin
      r_rspId  <= w_grantIdx;
      r_rspQ   <= '1;
      r_rspR   <= w_selX;
      r_rspErr <= ERR_DIV0;
    end else if (r_state == ST_WAIT && div_done) begin
      r_rspId  <= r_id;
      r_rspQ   <= div_q;
      r_rspR   <= div_r;
      r_rspErr <= ERR_OK;
    end else if (r_state == ST_WAIT && w_timeout) begin
      r_rspId  <= r_id;
      r_rspQ   <= '0;
      r_rspR   <= '0;
      r_rspErr <= ERR_TMO;
    end
  end

endmodule

// File: tb/tb_rdd_arbiter.sv
// Bench for rdd_arbiter: a behavioural divider with adjustable latency, a
// response scoreboard, a table of single-request vectors and hand-written
// sequences for fairness, timeout, late done and mid-division reset.
module tb_rdd_arbiter;

  import rdd_pkg::*;

  localparam int W       = 8;
  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 64;
  localparam int IW      = 2;

  typedef struct {
    logic [IW-1:0] id;
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic [1:0]    err;
  } rspT;

  typedef struct {
    logic [IW-1:0] id;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [W-1:0]  expQ;
    logic [W-1:0]  expR;
    logic [1:0]    expErr;
  } vecT;

  logic               clk;
  logic               reset;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_x;
  logic [N_REQ*W-1:0] req_y;
  logic [N_REQ-1:0]   req_ready;
  logic               rsp_valid;
  logic [IW-1:0]      rsp_id;
  logic [W-1:0]       rsp_q;
  logic [W-1:0]       rsp_r;
  logic [1:0]         rsp_err;
  logic               busy;
  logic [W-1:0]       div_x;
  logic [W-1:0]       div_y;
  logic               div_start;
  logic               div_done;
  logic [W-1:0]       div_q;
  logic [W-1:0]       div_r;

  rspT sbQ[$];
  rspT monE;
  vecT vecs [0:7];

  int checks = 0;
  int errors = 0;
  int cycleNum = 0;
  int startCount = 0;
  int expStarts = 0;

  int divLatency = 5;
  bit divHold = 1'b0;
  int lateDoneReqs = 0;
  int lateDoneSeen = 0;
  int doneCycle = -10;
  int doneCount = 0;
  int divCnt = 0;
  logic [W-1:0] pendQ;
  logic [W-1:0] pendR;

  rdd_arbiter #(
    .W       (W),
    .N_REQ   (N_REQ),
    .TIMEOUT (TIMEOUT),
    .IW      (IW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_q     (rsp_q),
    .rsp_r     (rsp_r),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .div_x     (div_x),
    .div_y     (div_y),
    .div_start (div_start),
    .div_done  (div_done),
    .div_q     (div_q),
    .div_r     (div_r)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used for latency measurements.
  initial begin
    forever begin
      @(posedge clk);
      cycleNum++;
    end
  end

  // Behavioural divider: sees div_start just after the edge, answers after
  // divLatency cycles unless held, and can fire a stray done on request.
  initial begin
    div_done = 1'b0;
    div_q = '0;
    div_r = '0;
    forever begin
      @(posedge clk);
      #2;
      div_done = 1'b0;
      if (lateDoneReqs != lateDoneSeen) begin
        lateDoneSeen = lateDoneReqs;
        div_done = 1'b1;
        div_q = 8'h55;
        div_r = 8'h55;
        doneCycle = cycleNum;
        doneCount++;
      end else if (divCnt > 0) begin
        divCnt--;
        if (divCnt == 0) begin
          div_done = 1'b1;
          div_q = pendQ;
          div_r = pendR;
          doneCycle = cycleNum;
          doneCount++;
        end
      end
      if (div_start && !divHold && div_y != 0) begin
        divCnt = divLatency;
        pendQ = div_x / div_y;
        pendR = div_x % div_y;
      end
    end
  end

  // Response monitor: counts start pulses and checks every response against
  // the oldest scoreboard entry, including done-to-response latency.
  initial begin
    forever begin
      @(negedge clk);
      if (div_start) begin
        startCount++;
      end
      if (rsp_valid) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedRsp: got rsp id=%0d q=%0h err=%0d, required no response",
                   rsp_id, rsp_q, rsp_err);
        end else begin
          monE = sbQ.pop_front();
          checkOutput("rspId", int'(rsp_id), int'(monE.id));
          checkOutput("rspQ", int'(rsp_q), int'(monE.q));
          checkOutput("rspR", int'(rsp_r), int'(monE.r));
          checkOutput("rspErr", int'(rsp_err), int'(monE.err));
          if (monE.err == ERR_OK) begin
            checkOutput("rspLatency", cycleNum, doneCycle + 1);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic failBound(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired, got no event, expected one", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic rspT mkRsp(input int id, input int q, input int r, input logic [1:0] err);
    rspT e;
    e.id = IW'(id);
    e.q = W'(q);
    e.r = W'(r);
    e.err = err;
    return e;
  endfunction

  task automatic waitIdle();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      sample();
      if (!busy) begin
        found = 1'b1;
      end
    end
    if (!found) begin
      failBound("waitIdle");
    end
  endtask

  task automatic checkAllZero();
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstReady", int'(req_ready), 0);
    checkOutput("rstRspValid", int'(rsp_valid), 0);
    checkOutput("rstDivStart", int'(div_start), 0);
    checkOutput("rstDivX", int'(div_x), 0);
    checkOutput("rstDivY", int'(div_y), 0);
    checkOutput("rstRspQ", int'(rsp_q), 0);
    checkOutput("rstRspR", int'(rsp_r), 0);
    checkOutput("rstRspErr", int'(rsp_err), 0);
    checkOutput("rstRspId", int'(rsp_id), 0);
  endtask

  // Reset held low for exactly one sampling edge; pending scoreboard
  // entries belong to the aborted transaction and are discarded.
  task automatic doReset(input bit checkZeros);
    tick();
    reset = 1'b0;
    req_valid = '0;
    sbQ.delete();
    tick();
    reset = 1'b1;
    sample();
    if (checkZeros) begin
      checkAllZero();
    end
  endtask

  // One table vector: single request, accept strobe, start (or not) one
  // cycle later, operands stable on the divider until the response.
  task automatic applyStimulus(input vecT v);
    logic [N_REQ-1:0] expReady;
    bit got;
    waitIdle();
    tick();
    expReady = '0;
    expReady[v.id] = 1'b1;
    req_valid = expReady;
    req_x[int'(v.id)*W +: W] = v.x;
    req_y[int'(v.id)*W +: W] = v.y;
    sample();
    checkOutput("acceptReady", int'(req_ready), int'(expReady));
    if (req_ready == expReady) begin
      sbQ.push_back(mkRsp(int'(v.id), int'(v.expQ), int'(v.expR), v.expErr));
      if (v.y != 0) begin
        expStarts++;
      end
    end
    tick();
    req_valid = '0;
    sample();
    checkOutput("startAfterAccept", int'(div_start), int'(v.y != 0));
    if (v.y == 0) begin
      checkOutput("div0RspLatency", int'(rsp_valid), 1);
    end else begin
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
        if (rsp_valid) begin
          got = 1'b1;
        end else begin
          checkOutput("divXStable", int'(div_x), int'(v.x));
          checkOutput("divYStable", int'(div_y), int'(v.y));
          sample();
        end
      end
      if (!got) begin
        failBound("rspWait");
      end
    end
  endtask

  // Holds the requesters in mask continuously and checks the order in which
  // they are granted against expOrder.
  task automatic runGrantSequence(input logic [N_REQ-1:0] mask, input int nGrants,
                                  input int expOrder [0:7]);
    int got;
    int seen;
    int xv;
    int yv;
    got = 0;
    waitIdle();
    tick();
    for (int i = 0; i < N_REQ; i++) begin
      req_x[i*W +: W] = W'(20 + i * 37);
      req_y[i*W +: W] = W'(3 + i);
    end
    req_valid = mask;
    for (int k = 0; k < 600 && got < nGrants; k++) begin
      sample();
      if (req_ready != '0) begin
        seen = 0;
        for (int i = 0; i < N_REQ; i++) begin
          if (req_ready[i]) begin
            seen = i;
          end
        end
        checkOutput("grantOneHot", $countones(req_ready), 1);
        checkOutput("grantOrder", seen, expOrder[got]);
        xv = 20 + seen * 37;
        yv = 3 + seen;
        sbQ.push_back(mkRsp(seen, xv / yv, xv % yv, ERR_OK));
        expStarts++;
        got++;
      end
      tick();
      if (got == nGrants) begin
        req_valid = '0;
      end
    end
    req_valid = '0;
    if (got < nGrants) begin
      failBound("grantSequence");
    end
    waitIdle();
  endtask

  int ordA [0:7];
  int startCyc;
  int doneMark;
  bit gotRsp;
  bit gotGrant;

  initial begin
    reset = 1'b0;
    req_valid = '0;
    req_x = '0;
    req_y = '0;

    vecs[0] = '{id: 2'd0, x: 8'd8,   y: 8'd13,  expQ: 8'd0,   expR: 8'd8,  expErr: ERR_OK};
    vecs[1] = '{id: 2'd2, x: 8'd100, y: 8'd7,   expQ: 8'd14,  expR: 8'd2,  expErr: ERR_OK};
    vecs[2] = '{id: 2'd1, x: 8'd45,  y: 8'd0,   expQ: 8'hFF,  expR: 8'd45, expErr: ERR_DIV0};
    vecs[3] = '{id: 2'd3, x: 8'd255, y: 8'd16,  expQ: 8'd15,  expR: 8'd15, expErr: ERR_OK};
    vecs[4] = '{id: 2'd0, x: 8'd200, y: 8'd1,   expQ: 8'd200, expR: 8'd0,  expErr: ERR_OK};
    vecs[5] = '{id: 2'd2, x: 8'd7,   y: 8'd7,   expQ: 8'd1,   expR: 8'd0,  expErr: ERR_OK};
    vecs[6] = '{id: 2'd1, x: 8'd0,   y: 8'd5,   expQ: 8'd0,   expR: 8'd0,  expErr: ERR_OK};
    vecs[7] = '{id: 2'd3, x: 8'd255, y: 8'd255, expQ: 8'd1,   expR: 8'd0,  expErr: ERR_OK};

    $display("[TB] reset state");
    doReset(1'b1);

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
    end

    $display("[TB] fairness with requesters 0 and 2 from reset");
    doReset(1'b0);
    ordA = '{0, 2, 0, 2, 0, 0, 0, 0};
    runGrantSequence(4'b0101, 4, ordA);

    $display("[TB] fairness with all requesters from reset");
    doReset(1'b0);
    ordA = '{0, 1, 2, 3, 0, 0, 0, 0};
    runGrantSequence(4'b1111, 5, ordA);

    $display("[TB] divider timeout and late done");
    waitIdle();
    divHold = 1'b1;
    tick();
    req_valid = 4'b0010;
    req_x[1*W +: W] = 8'd50;
    req_y[1*W +: W] = 8'd3;
    sample();
    checkOutput("tmoAccept", int'(req_ready), 2);
    sbQ.push_back(mkRsp(1, 0, 0, ERR_TMO));
    expStarts++;
    tick();
    req_valid = '0;
    sample();
    checkOutput("tmoStart", int'(div_start), 1);
    startCyc = cycleNum;
    gotRsp = 1'b0;
    for (int k = 0; k < 200 && !gotRsp; k++) begin
      sample();
      if (rsp_valid) begin
        gotRsp = 1'b1;
      end
    end
    if (!gotRsp) begin
      failBound("tmoRsp");
    end else begin
      checkOutput("tmoLatency", cycleNum - startCyc, TIMEOUT + 1);
    end
    lateDoneReqs++;
    for (int k = 0; k < 4; k++) begin
      sample();
      checkOutput("lateDoneIgnored", int'(rsp_valid), 0);
    end
    checkOutput("lateDoneFired", int'(lateDoneSeen == lateDoneReqs), 1);
    divHold = 1'b0;

    $display("[TB] reset during WAIT");
    waitIdle();
    divLatency = 20;
    tick();
    req_valid = 4'b0100;
    req_x[2*W +: W] = 8'd90;
    req_y[2*W +: W] = 8'd9;
    sample();
    checkOutput("midAccept", int'(req_ready), 4);
    sbQ.push_back(mkRsp(2, 10, 0, ERR_OK));
    expStarts++;
    tick();
    req_valid = '0;
    sample();
    checkOutput("midStart", int'(div_start), 1);
    repeat (3) sample();
    checkOutput("busyBeforeReset", int'(busy), 1);
    doneMark = doneCount;
    doReset(1'b1);
    gotRsp = 1'b0;
    for (int k = 0; k < 60 && !gotRsp; k++) begin
      sample();
      if (doneCount != doneMark) begin
        gotRsp = 1'b1;
      end
    end
    if (!gotRsp) begin
      failBound("staleDone");
    end
    for (int k = 0; k < 3; k++) begin
      sample();
      checkOutput("staleDoneNoRsp", int'(rsp_valid), 0);
      checkOutput("staleDoneIdle", int'(busy), 0);
    end
    divLatency = 5;

    tick();
    req_valid = 4'b1010;
    req_x[1*W +: W] = 8'd77;
    req_y[1*W +: W] = 8'd8;
    req_x[3*W +: W] = 8'd200;
    req_y[3*W +: W] = 8'd9;
    sample();
    checkOutput("ptrAfterReset", int'(req_ready), 2);
    sbQ.push_back(mkRsp(1, 9, 5, ERR_OK));
    expStarts++;
    tick();
    req_valid = 4'b1000;
    gotGrant = 1'b0;
    for (int k = 0; k < 200 && !gotGrant; k++) begin
      sample();
      if (req_ready != '0) begin
        gotGrant = 1'b1;
        checkOutput("req3Grant", int'(req_ready), 8);
        sbQ.push_back(mkRsp(3, 22, 2, ERR_OK));
        expStarts++;
      end
      tick();
      if (gotGrant) begin
        req_valid = '0;
      end
    end
    req_valid = '0;
    if (!gotGrant) begin
      failBound("req3Grant");
    end
    waitIdle();
    repeat (3) sample();

    checkOutput("scoreboardEmpty", sbQ.size(), 0);
    checkOutput("startPulseCount", startCount, expStarts);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rdd_arbiter.md
Name: rdd_arbiter

Overview:
Round-robin arbiter and sequencer that shares one restoring divider (rdd, W-bit) between N_REQ requesters. It accepts one request at a time, drives the divider operands and start pulse, and waits for the divider's done. It then returns quotient, remainder and a status code on a shared response bus tagged with the requester id. It also handles divide-by-zero locally and aborts hung divisions via a timeout counter.

Parameters:
W, 8, operand/result width (matches divider)
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 64, max cycles in WAIT before abort (>= W+4)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
req_valid  in  N_REQ  per-requester request valid
req_x  in  N_REQ*W  dividends, requester i at [i*W +: W]
req_y  in  N_REQ*W  divisors, same packing
req_ready  out  N_REQ  one-hot accept strobe
rsp_valid  out  1  one-cycle response pulse
rsp_id  out  $clog2(N_REQ)  requester index of response
rsp_q  out  W  quotient
rsp_r  out  W  remainder
rsp_err  out  2  00 ok, 01 divide-by-zero, 10 timeout
busy  out  1  high in any state except IDLE
div_x  out  W  divider dividend
div_y  out  W  divider divisor
div_start  out  1  divider start pulse
div_done  in  1  divider done tick
div_q  in  W  divider quotient
div_r  in  W  divider remainder

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, rr_ptr=0, all outputs 0, timeout counter 0. Reset applies in any state, including mid-WAIT. The divider is not told; its later done is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod N_REQ. If any request is valid:
  - req_ready[grant]=1 combinationally, this cycle only.
  - Latch x, y and id into internal registers.
  - Set rr_ptr = grant+1 mod N_REQ.
  - If y==0, go to RESP with q=all-ones, r=x, err=01. Otherwise go to ISSUE.
  - If no request is valid, req_ready=0.
- ISSUE: div_start=1 for exactly one cycle. Clear the counter. Go to WAIT.
- div_x and div_y are driven from the latched registers and held stable from ISSUE until the state leaves WAIT.
- WAIT: the counter increments each cycle.
  - On div_done=1: capture div_q and div_r, err=00, go to RESP.
  - Else if counter==TIMEOUT-1: q=0, r=0, err=10, go to RESP.
  - If div_done arrives in the same cycle as the timeout, div_done wins.
- RESP: rsp_valid=1 with rsp_id, rsp_q, rsp_r and rsp_err valid for that cycle only. Go to IDLE. The response bus holds its value after the pulse; consumers sample only when rsp_valid=1.
- div_done outside WAIT is ignored.
- req_valid may drop without acceptance; no request is ever lost once accepted.
- Latency:
  - Normal: accept at cycle T, div_start at T+1. If the divider done arrives at cycle D, rsp_valid is at D+1.
  - Divide-by-zero: rsp_valid at T+1.
  - Back-to-back: the next accept happens no earlier than the cycle after RESP.
- Fairness: with all N_REQ requesting continuously, the grant order is 0, 1, ..., N_REQ-1, 0, ...

Decomposition:
- Shared package rdd_pkg holds:
  - State encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3).
  - Error codes ERR_OK=2'b00, ERR_DIV0=2'b01, ERR_TMO=2'b10.
- One natural sub-module: rr_grant (combinational round-robin priority search from rr_ptr, producing one-hot plus index). The FSM stays in rdd_arbiter.
- The divider instance lives at the level above; it is not inside this block.

Test Plan:
- Single request, req0 x=8, y=13 -> req_ready[0] one cycle, div_start one cycle later. After div_done: rsp_valid, id=0, q=0, r=8, err=00.
- req2 x=100, y=7 -> rsp id=2, q=14, r=2, err=00. div_x/div_y stable 100/7 throughout WAIT.
- req1 x=45, y=0 -> no div_start. rsp_valid exactly 1 cycle after accept: q=8'hFF, r=45, err=01.
- req0 and req2 valid simultaneously from reset, requests re-asserted:
  - Grants must come in the order 0, 2, 0, 2.
  - Then with req1 and req3 added, the order must be 0, 1, 2, 3.
- Divider model withholds done -> rsp_valid TIMEOUT+1 cycles after div_start with err=10, q=0, r=0. A late div_done afterwards is ignored, with no extra rsp_valid.
- reset low for one cycle mid-WAIT -> next cycle state IDLE, busy=0, all outputs 0, rr_ptr=0. The following req3 request completes normally.
